// File: rtl/risc_pkg.sv
// risc_pkg: shared instruction-word defaults and fetch FSM state encoding.
package risc_pkg;
  localparam int INSTR_WID_DEF = 16;
  localparam logic [INSTR_WID_DEF-1:0] NOP_INSTR_DEF = 16'h0000;
  typedef enum logic {ST_RUN, ST_LOAD} fetch_state_t;
endpackage

// File: rtl/instr_fetch_mem_if.sv
// instr_fetch_mem_if: fetch and program-load channel between core/loader and instruction memory.
interface instr_fetch_mem_if #(
  parameter int PROG_CTR_WID = 10,
  parameter int INSTR_WID = 16
);
  logic [PROG_CTR_WID-1:0] prog_ctr;
  logic stall;
  logic flush;
  logic [INSTR_WID-1:0] instr_mem_out;
  logic instr_valid;
  logic ld_start;
  logic ld_valid;
  logic [INSTR_WID-1:0] ld_data;
  logic ld_last;
  logic ld_ready;
  logic loading;
  logic par_err;
  modport master (
    output prog_ctr, stall, flush, ld_start, ld_valid, ld_data, ld_last,
    input instr_mem_out, instr_valid, ld_ready, loading, par_err
  );
  modport slave (
    input prog_ctr, stall, flush, ld_start, ld_valid, ld_data, ld_last,
    output instr_mem_out, instr_valid, ld_ready, loading, par_err
  );
endinterface

// File: rtl/instr_mem_ram.sv
// instr_mem_ram: single-port synchronous RAM; a write cycle leaves dout untouched.
module instr_mem_ram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    else if (re) dout <= mem[addr];
  end
endmodule

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: registered instruction fetch with stall/flush and streamed program load.
// Define INSTR_MEM_PARITY_EN to store an even-parity bit per word and flag corrupted fetches.
module instr_fetch_mem
  import risc_pkg::*;
#(
  parameter int PROG_CTR_WID = 10,
  parameter int INSTR_WID = INSTR_WID_DEF,
  parameter logic [INSTR_WID-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter bit LOAD_ON_RESET = 1'b0
) (
  input logic clk,
  input logic rst_n,
  instr_fetch_mem_if.slave bus
);
`ifdef INSTR_MEM_PARITY_EN
  localparam int WW = INSTR_WID + 1;
`else
  localparam int WW = INSTR_WID;
`endif
  fetch_state_t state;
  logic [PROG_CTR_WID-1:0] ld_ptr;
  logic blank, ready, accept, re, perr;
  logic [WW-1:0] din, dout;
  // a beat presented on the reset edge is dropped, so reset cleanly aborts a load
  assign accept = ready & bus.ld_valid & rst_n;
  assign re = state == ST_RUN & ~bus.ld_start & ~bus.flush & ~bus.stall;
`ifdef INSTR_MEM_PARITY_EN
  assign din = {^bus.ld_data, bus.ld_data};
  assign perr = ~blank & ^dout;
`else
  assign din = bus.ld_data;
  assign perr = 1'b0;
`endif
  instr_mem_ram #(.AW(PROG_CTR_WID), .DW(WW)) u_ram (
    .clk,
    .we(accept),
    .re,
    .addr(state == ST_LOAD ? ld_ptr : bus.prog_ctr),
    .din,
    .dout
  );
  // dout only advances on a fetch, so stall holding is free; blank masks it to NOP
  assign bus.instr_mem_out = blank ? NOP_INSTR : dout[INSTR_WID-1:0];
  assign bus.instr_valid = ~blank & ~perr;
  assign bus.par_err = perr;
  assign bus.ld_ready = ready;
  assign bus.loading = state == ST_LOAD;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD_ON_RESET ? ST_LOAD : ST_RUN;
      ld_ptr <= '0;
      blank <= 1'b1;
      ready <= 1'b0;
    end else if (state == ST_LOAD) begin
      blank <= 1'b1;
      ready <= ~(accept & bus.ld_last);
      if (accept) ld_ptr <= ld_ptr + PROG_CTR_WID'(1);
      if (accept & bus.ld_last) state <= ST_RUN;
    end else if (bus.ld_start) begin
      state <= ST_LOAD;
      ld_ptr <= '0;
      blank <= 1'b1;
      ready <= 1'b1;
    end else if (bus.flush) begin
      blank <= 1'b1;
    end else if (!bus.stall) begin
      blank <= 1'b0;
    end
  end
endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem: randomized self-checking bench against a word-array reference model.
module tb_instr_fetch_mem;
  import risc_pkg::*;
  localparam logic [15:0] NOP = 16'h0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errors = 0;
  logic [15:0] ref_a [1024];
  int known_a = 0;
  logic [15:0] ref_b [8];
  always #5 clk = ~clk;

  instr_fetch_mem_if #(.PROG_CTR_WID(10), .INSTR_WID(16)) a ();
  instr_fetch_mem_if #(.PROG_CTR_WID(3), .INSTR_WID(16)) b ();

  instr_fetch_mem #(.PROG_CTR_WID(10), .INSTR_WID(16), .NOP_INSTR(NOP), .LOAD_ON_RESET(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(a)
  );
  instr_fetch_mem #(.PROG_CTR_WID(3), .INSTR_WID(16), .NOP_INSTR(NOP), .LOAD_ON_RESET(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {a.stall, a.flush, a.ld_start, a.ld_valid, a.ld_last} = '0;
    a.ld_data = '0;
    a.prog_ctr = '0;
    {b.stall, b.flush, b.ld_start, b.ld_valid, b.ld_last} = '0;
    b.ld_data = '0;
    b.prog_ctr = '0;
  endtask

  // streams q into dut from word 0, with random bubbles and ignored stall/flush/ld_start
  task automatic load_a(input logic [15:0] q[$]);
    int ptr = 0;
    a.ld_start = 1'b1;
    a.flush = 1'($urandom_range(0, 1));
    a.stall = 1'($urandom_range(0, 1));
    cyc();
    vectors++;
    if (a.loading !== 1'b1 || a.ld_ready !== 1'b1 || a.instr_valid !== 1'b0 || a.instr_mem_out !== NOP) begin
      errors++;
      $display("FAIL load_enter: loading=%b ready=%b valid=%b out=%h required 1 1 0 %h",
               a.loading, a.ld_ready, a.instr_valid, a.instr_mem_out, NOP);
    end
    for (int i = 0; i < q.size();) begin
      a.ld_start = 1'($urandom_range(0, 1));
      a.stall = 1'($urandom_range(0, 1));
      a.flush = 1'($urandom_range(0, 1));
      a.ld_valid = ($urandom_range(0, 3) != 0);
      a.ld_data = q[i];
      a.ld_last = a.ld_valid ? (i == q.size() - 1) : 1'($urandom_range(0, 1));
      a.prog_ctr = 10'($urandom);
      cyc();
      if (a.ld_valid) begin
        ref_a[ptr] = q[i];
        ptr = (ptr + 1) % 1024;
        i++;
      end
      if (i < q.size()) begin
        vectors++;
        if (a.loading !== 1'b1 || a.ld_ready !== 1'b1 || a.instr_valid !== 1'b0 || a.instr_mem_out !== NOP) begin
          errors++;
          $display("FAIL load_busy: loading=%b ready=%b valid=%b out=%h required 1 1 0 %h",
                   a.loading, a.ld_ready, a.instr_valid, a.instr_mem_out, NOP);
        end
      end
    end
    {a.ld_start, a.ld_valid, a.ld_last, a.stall, a.flush} = '0;
    vectors++;
    if (a.loading !== 1'b0 || a.ld_ready !== 1'b0 || a.instr_valid !== 1'b0 || a.instr_mem_out !== NOP) begin
      errors++;
      $display("FAIL load_exit: loading=%b ready=%b valid=%b out=%h required 0 0 0 %h",
               a.loading, a.ld_ready, a.instr_valid, a.instr_mem_out, NOP);
    end
    if (q.size() > known_a) known_a = q.size() > 1024 ? 1024 : q.size();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    cyc();
    cyc();
    vectors++;
    if (a.instr_mem_out !== NOP || a.instr_valid !== 1'b0 || a.ld_ready !== 1'b0 || a.loading !== 1'b0 || a.par_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: out=%h valid=%b ready=%b loading=%b perr=%b required %h 0 0 0 0",
               a.instr_mem_out, a.instr_valid, a.ld_ready, a.loading, a.par_err, NOP);
    end
    vectors++;
    if (b.loading !== 1'b1 || b.ld_ready !== 1'b0 || b.instr_valid !== 1'b0 || b.instr_mem_out !== NOP) begin
      errors++;
      $display("FAIL reset_b: loading=%b ready=%b valid=%b out=%h required 1 0 0 %h",
               b.loading, b.ld_ready, b.instr_valid, b.instr_mem_out, NOP);
    end
    rst_n = 1'b1;
    a.stall = 1'b1;
    cyc();
    a.stall = 1'b0;
    vectors++;
    if (a.loading !== 1'b0 || a.ld_ready !== 1'b0 || b.loading !== 1'b1 || b.ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: a.loading=%b a.ready=%b b.loading=%b b.ready=%b required 0 0 1 1",
               a.loading, a.ld_ready, b.loading, b.ld_ready);
    end
  endtask

  task automatic test_fetch();
    logic [15:0] q[$];
    for (int i = 0; i < 5; i++) q.push_back(16'($urandom));
    q.push_back(16'hA1B2);
    load_a(q);
    a.prog_ctr = 10'd5;
    cyc();
    vectors++;
    if (a.instr_mem_out !== 16'hA1B2 || a.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL fetch_pc5: out=%h valid=%b required a1b2 1", a.instr_mem_out, a.instr_valid);
    end
  endtask

  task automatic test_load_fetch();
    logic [15:0] q[$] = '{16'h1111, 16'h2222, 16'h3333};
    load_a(q);
    for (int i = 0; i < 3; i++) begin
      a.prog_ctr = 10'(i);
      cyc();
      vectors++;
      if (a.instr_mem_out !== q[i] || a.instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL load_fetch[%0d]: out=%h valid=%b required %h 1", i, a.instr_mem_out, a.instr_valid, q[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    a.prog_ctr = 10'd1;
    cyc();
    a.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a.prog_ctr = 10'($urandom);
      cyc();
      vectors++;
      if (a.instr_mem_out !== 16'h2222 || a.instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: out=%h valid=%b required 2222 1", i, a.instr_mem_out, a.instr_valid);
      end
    end
    a.flush = 1'b1;
    cyc();
    vectors++;
    if (a.instr_mem_out !== NOP || a.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_flush: out=%h valid=%b required %h 0", a.instr_mem_out, a.instr_valid, NOP);
    end
    a.flush = 1'b0;
    a.stall = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] exp_out = NOP;
    logic exp_valid = 1'b0;
    logic [15:0] q[$];
    for (int i = 0; i < 40; i++) q.push_back(16'($urandom));
    load_a(q);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        q.delete();
        for (int i = 0; i < int'($urandom_range(1, 12)); i++) q.push_back(16'($urandom));
        load_a(q);
        exp_out = NOP;
        exp_valid = 1'b0;
      end else begin
        a.prog_ctr = 10'($urandom_range(0, known_a - 1));
        a.stall = ($urandom_range(0, 3) == 0);
        a.flush = ($urandom_range(0, 6) == 0);
        cyc();
        if (a.flush) begin
          exp_out = NOP;
          exp_valid = 1'b0;
        end else if (!a.stall) begin
          exp_out = ref_a[a.prog_ctr];
          exp_valid = 1'b1;
        end
        vectors++;
        if (a.instr_mem_out !== exp_out || a.instr_valid !== exp_valid || a.par_err !== 1'b0) begin
          errors++;
          $display("FAIL random[%0d]: out=%h valid=%b perr=%b required %h %b 0",
                   n, a.instr_mem_out, a.instr_valid, a.par_err, exp_out, exp_valid);
        end
      end
    end
    a.stall = 1'b0;
    a.flush = 1'b0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 9; i++) begin
      b.ld_valid = 1'b1;
      b.ld_data = 16'($urandom);
      b.ld_last = (i == 8);
      ref_b[i % 8] = b.ld_data;
      cyc();
    end
    b.ld_valid = 1'b0;
    b.ld_last = 1'b0;
    vectors++;
    if (b.loading !== 1'b0 || b.ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL wrap_exit: loading=%b ready=%b required 0 0", b.loading, b.ld_ready);
    end
    for (int i = 0; i < 8; i++) begin
      b.prog_ctr = 3'(i);
      cyc();
      vectors++;
      if (b.instr_mem_out !== ref_b[i] || b.instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL wrap_word[%0d]: out=%h valid=%b required %h 1", i, b.instr_mem_out, b.instr_valid, ref_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    a.ld_start = 1'b1;
    cyc();
    a.ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a.ld_valid = 1'b1;
      a.ld_data = 16'($urandom);
      ref_a[i] = a.ld_data;
      cyc();
    end
    a.ld_data = ~ref_a[2];
    rst_n = 1'b0;
    cyc();
    vectors++;
    if (a.loading !== 1'b0 || a.ld_ready !== 1'b0 || a.instr_valid !== 1'b0 || a.instr_mem_out !== NOP || a.par_err !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: loading=%b ready=%b valid=%b out=%h perr=%b required 0 0 0 %h 0",
               a.loading, a.ld_ready, a.instr_valid, a.instr_mem_out, a.par_err, NOP);
    end
    a.ld_valid = 1'b0;
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      a.prog_ctr = 10'(i);
      cyc();
      vectors++;
      if (a.instr_mem_out !== ref_a[i] || a.instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL abort_word[%0d]: out=%h valid=%b required %h 1", i, a.instr_mem_out, a.instr_valid, ref_a[i]);
      end
    end
  endtask

`ifdef INSTR_MEM_PARITY_EN
  task automatic test_parity();
    dut.u_ram.mem[1] = dut.u_ram.mem[1] ^ 17'h00008;
    a.prog_ctr = 10'd1;
    cyc();
    vectors++;
    if (a.par_err !== 1'b1 || a.instr_valid !== 1'b0 || a.instr_mem_out !== (ref_a[1] ^ 16'h0008)) begin
      errors++;
      $display("FAIL parity_hit: perr=%b valid=%b out=%h required 1 0 %h",
               a.par_err, a.instr_valid, a.instr_mem_out, ref_a[1] ^ 16'h0008);
    end
    a.prog_ctr = 10'd0;
    cyc();
    vectors++;
    if (a.par_err !== 1'b0 || a.instr_valid !== 1'b1 || a.instr_mem_out !== ref_a[0]) begin
      errors++;
      $display("FAIL parity_clear: perr=%b valid=%b out=%h required 0 1 %h",
               a.par_err, a.instr_valid, a.instr_mem_out, ref_a[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_load_fetch();
    test_stall_flush();
    test_random();
    test_wrap();
    test_reset_mid_load();
`ifdef INSTR_MEM_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
